// File: rtl/entropy_ac_scan_controller.sv
// rtl/entropy_ac_scan_controller.sv - AC coefficient scan sequencer feeding a run/level encoder
// Reads each slice coefficient-major, forwards data to the encoder and totals codeword bits.
module entropy_ac_scan_controller #(
  parameter int ENC_LATENCY = 5,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  num_blocks,
  output logic        busy,
  output logic        done,
  output logic        rd_en,
  output logic [4:0]  rd_block,
  output logic [5:0]  rd_coef,
  input  logic [31:0] rd_data,
  output logic        enc_rst_n,
  output logic [31:0] coeff_out,
  input  logic [31:0] cw_len,
  output logic [31:0] bit_count
);

  localparam int DL = MEM_LATENCY + 1 + ENC_LATENCY;

  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, DRAIN, DONE} state_t;

  state_t         state;
  logic [5:0]     nb;
  logic [DL-1:0]  vline;
  logic           last_block;
  logic           drain_empty;

  assign last_block  = ({1'b0, rd_block} == (nb - 6'd1));
  // The oldest stage is consumed this cycle, so only younger stages keep DRAIN alive.
  assign drain_empty = ~|vline[DL-2:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vline     <= '0;
      coeff_out <= '0;
    end else begin
      vline     <= {vline[DL-2:0], rd_en};
      coeff_out <= vline[MEM_LATENCY-1] ? rd_data : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      nb        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_block  <= '0;
      rd_coef   <= '0;
      enc_rst_n <= 1'b0;
      bit_count <= '0;
    end else begin
      if (state == IDLE && start)
        bit_count <= '0;
      else if (vline[DL-1])
        bit_count <= bit_count + cw_len;

      case (state)
        IDLE: begin
          if (start) begin
            nb    <= (num_blocks > 6'd32) ? 6'd32 : num_blocks;
            busy  <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          enc_rst_n <= 1'b1;
          if (nb == 6'd0) begin
            state <= DRAIN;
          end else begin
            state    <= SCAN;
            rd_en    <= 1'b1;
            rd_block <= '0;
            rd_coef  <= 6'd1;
          end
        end
        SCAN: begin
          if (last_block && rd_coef == 6'd63) begin
            state    <= DRAIN;
            rd_en    <= 1'b0;
            rd_block <= '0;
            rd_coef  <= '0;
          end else if (last_block) begin
            rd_block <= '0;
            rd_coef  <= rd_coef + 6'd1;
          end else begin
            rd_block <= rd_block + 5'd1;
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          enc_rst_n <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_entropy_ac_scan_controller.sv
// tb/tb_entropy_ac_scan_controller.sv - scoreboard bench for entropy_ac_scan_controller
module tb_entropy_ac_scan_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  num_blocks = '0;
  logic        busy, done, rd_en, enc_rst_n;
  logic [4:0]  rd_block;
  logic [5:0]  rd_coef;
  logic [31:0] rd_data = '0;
  logic [31:0] coeff_out, cw_len = '0, bit_count;

  entropy_ac_scan_controller dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_blocks(num_blocks),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_block(rd_block), .rd_coef(rd_coef),
    .rd_data(rd_data), .enc_rst_n(enc_rst_n), .coeff_out(coeff_out),
    .cw_len(cw_len), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard state
  logic [10:0] rdq[$];
  int    exp_nb = 0;
  int    cw_mode = 0;   // 0 random, 1 three in window / seven outside, 2 zero in window
  bit    zero_data = 1'b0;
  int    cyc = 0;
  bit    rh[16];
  logic [31:0] dh[16];
  logic [31:0] exp_bits = '0;
  logic [31:0] done_bits = '0;
  bit    in_slice = 1'b0;
  int    start_cyc = 0, first_rd = -1, last_rd = 0, reads = 0, enc_low = 0;
  int    slices_done = 0;

  always @(negedge clk) begin
    logic [31:0] exp_c;
    logic [10:0] e;
    bit win;
    cyc++;
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin rh[i] = 1'b0; dh[i] = '0; end
      rdq.delete();
      in_slice = 1'b0;
      exp_bits = '0;
    end else begin
      // read issued two cycles back -> data seen last cycle -> coeff_out now
      exp_c = rh[(cyc - 2) & 15] ? dh[(cyc - 1) & 15] : 32'd0;
      chk("coeff_out", coeff_out, exp_c);
      rh[cyc & 15] = rd_en;
      if (start && !busy) begin
        in_slice = 1'b1; start_cyc = cyc; reads = 0; first_rd = -1; enc_low = 0;
        exp_bits = '0;
      end
      if (busy && !enc_rst_n) enc_low++;
      if (rd_en) begin
        reads++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        if (rdq.size() == 0) chk("rd_extra", {21'd0, rd_block, rd_coef}, 32'hffff_ffff);
        else begin
          e = rdq.pop_front();
          chk("rd_addr", {21'd0, rd_block, rd_coef}, {21'd0, e});
        end
      end
      rd_data = zero_data ? 32'd0 : $urandom;
      dh[cyc & 15] = rd_data;
      win = rh[(cyc - 7) & 15];
      case (cw_mode)
        1:       cw_len = win ? 32'd3 : 32'd7;
        2:       cw_len = win ? 32'd0 : $urandom;
        default: cw_len = $urandom;
      endcase
      if (win) exp_bits += cw_len;
      if (done) begin
        if (!in_slice) chk("done_unexpected", {31'd0, done}, 32'd0);
        else begin
          chk("done_cycle", cyc, (exp_nb == 0) ? start_cyc + 3 : last_rd + 8);
          chk("read_count", reads, 63 * exp_nb);
          if (reads > 0) chk("reads_contig", last_rd - first_rd + 1, reads);
          chk("rdq_left", rdq.size(), 0);
          chk("bit_count", bit_count, exp_bits);
          chk("busy_at_done", {31'd0, busy}, 32'd1);
          chk("enc_rst_n_done", {31'd0, enc_rst_n}, 32'd1);
          chk("enc_low_cycles", enc_low, 1);
          done_bits = exp_bits;
          in_slice = 1'b0;
          slices_done++;
        end
      end
    end
  end

  task automatic begin_slice(input int nb);
    int nbe;
    for (int i = 0; i < 3000 && busy; i++) @(posedge clk);
    @(posedge clk); #2;
    nbe = (nb > 32) ? 32 : nb;
    for (int c = 1; c <= 63; c++)
      for (int b = 0; b < nbe; b++) begin
        logic [4:0] bb;
        logic [5:0] cc;
        bb = b[4:0]; cc = c[5:0];
        rdq.push_back({bb, cc});
      end
    exp_nb = nbe;
    start = 1'b1; num_blocks = nb[5:0];
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_slice();
    int target;
    target = slices_done + 1;
    for (int i = 0; i < 3000 && slices_done < target; i++) @(posedge clk);
    chk("done_seen", slices_done, target);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_rd_en"}, {31'd0, rd_en}, 0);
    chk({tag, "_rd_block"}, {27'd0, rd_block}, 0);
    chk({tag, "_rd_coef"}, {26'd0, rd_coef}, 0);
    chk({tag, "_coeff_out"}, coeff_out, 0);
    chk({tag, "_bit_count"}, bit_count, 0);
    chk({tag, "_enc_rst_n"}, {31'd0, enc_rst_n}, 0);
  endtask

  initial begin
    #3 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (3) @(posedge clk);

    zero_data = 1'b1; cw_mode = 2;
    begin_slice(1); wait_slice();
    chk("nb1_bits", bit_count, 0);
    zero_data = 1'b0; cw_mode = 0;

    begin_slice(2); wait_slice();
    repeat (5) @(posedge clk);
    chk("bit_hold", bit_count, done_bits);

    cw_mode = 1;
    begin_slice(4); wait_slice();
    chk("nb4_bits", bit_count, 756);
    cw_mode = 0;

    begin_slice(3);
    repeat (50) @(posedge clk);
    #2 start = 1'b1; num_blocks = 6'd1;
    @(posedge clk); #2 start = 1'b0;
    wait_slice();
    chk("ignored_start_reads", reads, 189);

    begin_slice(2);
    repeat (40) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("midscan");
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("no_done_after_reset", slices_done, slices_done);
    begin_slice(1); wait_slice();

    begin_slice(0); wait_slice();
    chk("nb0_reads", reads, 0);
    chk("nb0_bits", bit_count, 0);

    begin_slice(40); wait_slice();
    chk("nb40_reads", reads, 2016);

    for (int k = 0; k < 4; k++) begin
      begin_slice($urandom_range(0, 40)); wait_slice();
    end

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/entropy_ac_scan_controller.md
ENTROPY_AC_SCAN_CONTROLLER -- requirements
Module: entropy_ac_scan_controller

Interface
REQ-001 Parameter: ENC_LATENCY, default 5, cycles from coeff_out presented to the matching cw_len from the AC run/level encoder.
REQ-002 Parameter: MEM_LATENCY, default 1, cycles from rd_en to valid rd_data.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low: port clk, input, 1, rising-edge clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request to scan one slice.
REQ-006 num_blocks  input  6  blocks in slice, sampled with start.
REQ-007 busy  output  1  high from accepted start until done.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 rd_en  output  1  coefficient memory read strobe.
REQ-010 rd_block  output  5  block index of current read.
REQ-011 rd_coef  output  6  coefficient (scan) index of current read.
REQ-012 rd_data  input  32  coefficient returned MEM_LATENCY cycles after rd_en.
REQ-013 enc_rst_n  output  1  registered active-low clear for the downstream encoder.
REQ-014 coeff_out  output  32  registered coefficient to encoder Coeff input.
REQ-015 cw_len  input  32  codeword length from encoder.
REQ-016 bit_count  output  32  total AC codeword bits of last slice.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, SCAN, DRAIN, DONE.
REQ-018 IDLE: start=1 -> CLEAR; num_blocks latched (0 -> no reads; >32 clamped to 32); bit_count cleared to 0; start ignored in all other states.
REQ-019 CLEAR lasts exactly 1 cycle with enc_rst_n=0; enc_rst_n SHALL be 0 in IDLE and CLEAR, 1 in SCAN, DRAIN, DONE.
REQ-020 SCAN: rd_en=1 every cycle, order coefficient-outer 1..63, block-inner 0..nb-1: (b0,c1),(b1,c1)..(bnb-1,c1),(b0,c2)..(bnb-1,c63); exactly 63*nb reads, no gaps.
REQ-021 SCAN -> DRAIN after the (bnb-1,c63) read; nb=0 -> CLEAR goes directly to DRAIN.
REQ-022 coeff_out SHALL equal rd_data registered one cycle after it is valid (MEM_LATENCY+1 cycles after rd_en), else 0.
REQ-023 A valid delay line of length MEM_LATENCY+1+ENC_LATENCY SHALL track reads; bit_count += cw_len only on cycles the delayed valid is 1; cw_len ignored otherwise.
REQ-024 bit_count adds SHALL wrap modulo 2^32.
REQ-025 DRAIN -> DONE when delay line is empty; DONE lasts 1 cycle with done=1, then IDLE.
REQ-026 done SHALL rise exactly MEM_LATENCY+ENC_LATENCY+2 cycles (8 by default) after the last rd_en cycle.
REQ-027 busy SHALL be 1 in CLEAR, SCAN, DRAIN, DONE; bit_count holds until next accepted start.

Reset
REQ-028 On reset_n=0 all state SHALL clear immediately: FSM IDLE, busy, done, rd_en, rd_block, rd_coef, coeff_out, bit_count = 0, enc_rst_n = 0, delay line empty.
REQ-029 Reset mid-scan SHALL abandon the slice with no done pulse; next start after release runs normally.

Verification
REQ-030 Reset asserted -> every output 0, including enc_rst_n.
REQ-031 nb=1, rd_data all 0 -> one enc_rst_n low cycle, 63 reads rd_coef 1..63 rd_block 0, done 8 cycles after last rd_en, bit_count=0.
REQ-032 nb=2 -> 126 reads in order (0,1),(1,1),(0,2),(1,2)..(1,63), contiguous.
REQ-033 nb=4, bench cw_len=3 inside valid window and 7 outside -> bit_count=756.
REQ-034 start pulsed during SCAN -> ignored, read count unchanged; reset_n low mid-SCAN -> outputs 0, no done, next start succeeds.
REQ-035 nb=0 -> no rd_en, done pulse, bit_count=0; nb=40 -> 2016 reads (clamped to 32).
